// File: rtl/board_matrix_if.sv
// Drop request, status and landed-move bundle for board_matrix.
// master drives requests and ticks; slave is the board store.
interface board_matrix_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic                   drop_valid;
  logic [CW-1:0]          drop_col;
  logic                   drop_colour;
  logic                   drop_ready;
  logic                   step;
  logic [1:0]             win;
  logic [COLS*ROWS*2-1:0] board;
  logic [COLS-1:0]        col_full;
  logic                   board_full;
  logic                   busy;
  logic                   done_valid;
  logic [CW-1:0]          done_col;
  logic [RW-1:0]          done_row;
  logic                   done_colour;
  logic                   reject;

  modport master (
    output drop_valid, drop_col, drop_colour,
    output step, win,
    input  drop_ready, board, col_full,
    input  board_full, busy, done_valid,
    input  done_col, done_row, done_colour,
    input  reject
  );

  modport slave (
    input  drop_valid, drop_col, drop_colour,
    input  step, win,
    output drop_ready, board, col_full,
    output board_full, busy, done_valid,
    output done_col, done_row, done_colour,
    output reject
  );
endinterface

// File: rtl/board_matrix.sv
// Connect-Four board store: cells, column heights,
// drop handshake and optional falling-piece animation.
module board_matrix #(
  parameter int COLS      = 7,
  parameter int ROWS      = 6,
  parameter int FALL_ANIM = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  board_matrix_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);
  localparam logic [CW:0] LCOLS = (CW+1)'(COLS);

  typedef enum logic {IDLE, FALL} state_t;

  state_t          r_state;
  logic [1:0]      r_cell [COLS][ROWS];
  logic [HW-1:0]   r_h [COLS];
  logic [CW-1:0]   r_col;
  logic            r_colour;
  logic [RW-1:0]   r_tgt;
  logic [RW-1:0]   r_fall;
  logic            r_done_valid;
  logic [CW-1:0]   r_done_col;
  logic [RW-1:0]   r_done_row;
  logic            r_done_colour;
  logic            r_reject;

  logic                   w_ready;
  logic                   w_acc;
  logic                   w_colok;
  logic                   w_full_sel;
  logic [HW-1:0]          w_h_sel;
  logic [RW-1:0]          w_row;
  logic [1:0]             w_code;
  logic [1:0]             w_fcode;
  logic [COLS-1:0]        w_full;
  logic [COLS*ROWS*2-1:0] w_board;

  always_comb begin
    w_full     = '0;
    w_full_sel = 1'b0;
    w_h_sel    = '0;
    for (int c = 0; c < COLS; c++) begin
      w_full[c] = (r_h[c] == HW'(ROWS));
      if (bus.drop_col == CW'(c)) begin
        w_full_sel = w_full[c];
        w_h_sel    = r_h[c];
      end
    end
  end

  assign w_ready = (r_state == IDLE) & (bus.win == 2'b00)
                 & reset & ~clear;
  assign w_acc   = bus.drop_valid & w_ready;
  assign w_colok = {1'b0, bus.drop_col} < LCOLS;
  assign w_row   = RW'(w_h_sel);
  assign w_code  = bus.drop_colour ? 2'b10 : 2'b01;
  assign w_fcode = r_colour ? 2'b10 : 2'b01;

  // The falling piece is drawn over its still-empty cell.
  always_comb begin
    w_board = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        w_board[(c*ROWS+r)*2 +: 2] = r_cell[c][r];
        if (r_state == FALL && r_col == CW'(c)
            && r_fall == RW'(r))
          w_board[(c*ROWS+r)*2 +: 2] = w_fcode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_colour      <= 1'b0;
      r_tgt         <= '0;
      r_fall        <= '0;
      r_done_valid  <= 1'b0;
      r_done_col    <= '0;
      r_done_row    <= '0;
      r_done_colour <= 1'b0;
      r_reject      <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        r_h[c] <= '0;
        for (int r = 0; r < ROWS; r++)
          r_cell[c][r] <= 2'b00;
      end
    end else begin
      r_done_valid <= 1'b0;
      r_reject     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            if (!w_colok || w_full_sel) begin
              r_reject <= 1'b1;
            end else if (FALL_ANIM == 0
                         || w_row == RW'(ROWS-1)) begin
              r_cell[bus.drop_col][w_row] <= w_code;
              r_h[bus.drop_col] <= w_h_sel + HW'(1);
              r_done_valid  <= 1'b1;
              r_done_col    <= bus.drop_col;
              r_done_row    <= w_row;
              r_done_colour <= bus.drop_colour;
            end else begin
              r_state  <= FALL;
              r_col    <= bus.drop_col;
              r_colour <= bus.drop_colour;
              r_tgt    <= w_row;
              r_fall   <= RW'(ROWS-1);
            end
          end
        end
        FALL: begin
          if (bus.step) begin
            if (r_fall == r_tgt) begin
              r_cell[r_col][r_tgt] <= w_fcode;
              r_h[r_col]    <= r_h[r_col] + HW'(1);
              r_done_valid  <= 1'b1;
              r_done_col    <= r_col;
              r_done_row    <= r_tgt;
              r_done_colour <= r_colour;
              r_state       <= IDLE;
            end else begin
              r_fall <= r_fall - RW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.drop_ready  = w_ready;
  assign bus.board       = w_board;
  assign bus.col_full    = w_full;
  assign bus.board_full  = &w_full;
  assign bus.busy        = (r_state == FALL);
  assign bus.done_valid  = r_done_valid;
  assign bus.done_col    = r_done_col;
  assign bus.done_row    = r_done_row;
  assign bus.done_colour = r_done_colour;
  assign bus.reject      = r_reject;
endmodule

// File: tb/tb_board_matrix.sv
// Directed bench for board_matrix: immediate, animated
// and 4x4 instances driven from one linear sequence.
module tb_board_matrix;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp2;

  always #5 clk = ~clk;

  board_matrix_if #(.COLS(7), .ROWS(6)) b0 ();
  board_matrix_if #(.COLS(7), .ROWS(6)) b1 ();
  board_matrix_if #(.COLS(4), .ROWS(4)) b2 ();

  board_matrix #(.COLS(7), .ROWS(6), .FALL_ANIM(0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b0));
  board_matrix #(.COLS(7), .ROWS(6), .FALL_ANIM(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b1));
  board_matrix #(.COLS(4), .ROWS(4), .FALL_ANIM(0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] o,
                     input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic stepn(input int n);
    for (int k = 0; k < n; k++) begin
      b1.step = 1'b1;
      tick();
      b1.step = 1'b0;
    end
  endtask

  initial begin
    b0.drop_valid = 0; b0.drop_col = 0; b0.drop_colour = 0;
    b0.step = 0; b0.win = 0;
    b1.drop_valid = 0; b1.drop_col = 0; b1.drop_colour = 0;
    b1.step = 0; b1.win = 0;
    b2.drop_valid = 0; b2.drop_col = 0; b2.drop_colour = 0;
    b2.step = 0; b2.win = 0;

    tick();
    tick();
    chk("rst_board", b0.board, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_dv", b0.done_valid, 0);
    chk("rst_rej", b0.reject, 0);
    chk("rst_rdy", b0.drop_ready, 0);
    chk("rst_cfull", b0.col_full, 0);
    chk("rst_bfull", b2.board_full, 0);
    chk("rst_drow", b0.done_row, 0);
    reset = 1'b1;
    #1;
    chk("rdy_up", b0.drop_ready, 1);

    // immediate stack into column 3
    b0.drop_valid = 1'b1;
    b0.drop_col = 3'd3;
    for (int i = 0; i < 6; i++) begin
      b0.drop_colour = i[0];
      tick();
      chk("stk_dv", b0.done_valid, 1);
      chk("stk_row", b0.done_row, i);
      chk("stk_col", b0.done_col, 3);
      chk("stk_clr", b0.done_colour, i[0]);
    end
    chk("stk_c3", b0.board[36 +: 12], 12'h999);
    chk("stk_full", b0.col_full, 7'b0001000);
    tick();
    chk("full_rej", b0.reject, 1);
    chk("full_dv", b0.done_valid, 0);
    chk("full_brd", b0.board, 84'h999 << 36);
    chk("full_rdy", b0.drop_ready, 1);
    b0.drop_col = 3'd7;
    tick();
    chk("bad_rej", b0.reject, 1);
    chk("bad_cf", b0.col_full, 7'b0001000);
    chk("bad_brd", b0.board, 84'h999 << 36);
    b0.drop_valid = 1'b0;
    tick();
    chk("rej_end", b0.reject, 0);

    // animated drop, step on accept edge ignored
    b1.drop_valid = 1'b1;
    b1.drop_col = 3'd0;
    b1.drop_colour = 1'b1;
    b1.step = 1'b1;
    tick();
    b1.drop_valid = 1'b0;
    b1.step = 1'b0;
    chk("an_busy", b1.busy, 1);
    chk("an_rdy", b1.drop_ready, 0);
    chk("an_r5", b1.board, 84'h2 << 10);
    stepn(1);
    chk("an_r4", b1.board, 84'h2 << 8);
    tick();
    chk("an_hold", b1.board, 84'h2 << 8);
    stepn(4);
    chk("an_r0", b1.board, 84'h2);
    chk("an_busy0", b1.busy, 1);
    chk("an_dv0", b1.done_valid, 0);
    stepn(1);
    chk("an_dv", b1.done_valid, 1);
    chk("an_row", b1.done_row, 0);
    chk("an_clr", b1.done_colour, 1);
    chk("an_idle", b1.busy, 0);
    chk("an_rdy1", b1.drop_ready, 1);
    chk("an_brd", b1.board, 84'h2);
    tick();
    chk("an_dv1", b1.done_valid, 0);

    // win raised mid-fall
    b1.drop_valid = 1'b1;
    b1.drop_col = 3'd1;
    b1.drop_colour = 1'b0;
    tick();
    b1.drop_valid = 1'b0;
    b1.win = 2'b01;
    stepn(5);
    chk("win_busy", b1.busy, 1);
    stepn(1);
    chk("win_dv", b1.done_valid, 1);
    chk("win_col", b1.done_col, 1);
    chk("win_rdy", b1.drop_ready, 0);
    b1.drop_valid = 1'b1;
    b1.drop_col = 3'd2;
    tick();
    chk("win_busy2", b1.busy, 0);
    chk("win_rej", b1.reject, 0);
    chk("win_brd", b1.board, 84'h1002);
    b1.drop_valid = 1'b0;
    b1.win = 2'b00;

    // clear during a fall
    b1.drop_valid = 1'b1;
    tick();
    b1.drop_valid = 1'b0;
    chk("clr_busy", b1.busy, 1);
    clear = 1'b1;
    #1;
    chk("clr_rdy", b1.drop_ready, 0);
    tick();
    clear = 1'b0;
    chk("clr_brd", b1.board, 0);
    chk("clr_busy0", b1.busy, 0);
    chk("clr_dv", b1.done_valid, 0);
    chk("clr_b0", b0.board, 0);

    // reset during a fall
    b1.drop_valid = 1'b1;
    tick();
    b1.drop_valid = 1'b0;
    chk("rf_busy", b1.busy, 1);
    reset = 1'b0;
    b1.step = 1'b1;
    tick();
    b1.step = 1'b0;
    chk("rf_brd", b1.board, 0);
    chk("rf_busy0", b1.busy, 0);
    chk("rf_dv", b1.done_valid, 0);
    reset = 1'b1;

    // fill the 4x4 board
    exp2 = '0;
    b2.drop_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b2.drop_col = 2'(i % 4);
      b2.drop_colour = (i / 4) % 2 == 1;
      tick();
      exp2 = exp2 | (32'(b2.drop_colour ? 2 : 1)
                     << (((i % 4) * 4 + i / 4) * 2));
      chk("fb_row", b2.done_row, i / 4);
      chk("fb_full", b2.board_full, i == 15);
    end
    chk("fb_brd", b2.board, exp2);
    b2.drop_col = 2'd0;
    tick();
    chk("fb_rej", b2.reject, 1);
    chk("fb_dv", b2.done_valid, 0);
    b2.drop_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/board_matrix.md
# board_matrix

Parametrised Connect-Four board store. It replaces the fixed 7-column × 6-row array of per-column instances with one block that holds every cell and a height counter for each column. Drop requests use a valid/ready handshake, and an optional falling-piece animation runs off a slow step tick. The block feeds the display with the flattened board and gives the win checker a one-cycle report of each landed move.

## Interface
- `COLS`, default 7: number of columns, at least 2.
- `ROWS`, default 6: number of rows, at least 2.
- `FALL_ANIM`, default 1: 1 means the piece falls one row per `step`; 0 means it lands immediately.
- Derived width `CW` = `$clog2(COLS)`.
- Derived width `RW` = `$clog2(ROWS)`.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-low. Low at a rising edge clears all state.
- `clear`, in, 1: synchronous new-game clear; same effect as reset.
- `drop_valid`, in, 1: drop request.
- `drop_col`, in, `CW`: target column, 0 is leftmost.
- `drop_colour`, in, 1: player colour. 0 writes cell code 01; 1 writes cell code 10.
- `drop_ready`, out, 1: block can accept a drop.
- `step`, in, 1: animation tick enable, one `clk` wide. Ignored when `FALL_ANIM`=0.
- `win`, in, 2: nonzero freezes the board against new drops.
- `board`, out, `COLS*ROWS*2`: cell (c, r) is at bits `[(c*ROWS+r)*2 +: 2]`, with r=0 the bottom row. Codes: 00 empty, 01 colour 0, 10 colour 1. The falling piece is overlaid.
- `col_full`, out, `COLS`: bit c high when column c holds `ROWS` pieces.
- `board_full`, out, 1: all columns full (draw).
- `busy`, out, 1: FALL state.
- `done_valid`, out, 1: one-cycle pulse when a piece lands.
- `done_col`, out, `CW`: column of the landed piece; valid while `done_valid` is high.
- `done_row`, out, `RW`: row of the landed piece; valid while `done_valid` is high.
- `done_colour`, out, 1: colour of the landed piece; valid while `done_valid` is high.
- `reject`, out, 1: one-cycle pulse when an accepted request is refused.

## Operation
- **Storage:**
  - 2-bit cell array.
  - Per-column height counter, width `$clog2(ROWS+1)`, range 0..`ROWS`.
  - Cell code 11 is never written.
- **FSM states:** IDLE and FALL.
- **Handshake:** `drop_ready` = (state==IDLE) & (`win`==0) & `reset` & !`clear`. A transfer happens when `drop_valid` & `drop_ready` are both high at a rising edge.
- **Accept in IDLE:**
  - If `drop_col` ≥ `COLS` or `col_full[drop_col]` is high: pulse `reject` and stay in IDLE. No state change.
  - Otherwise latch col, colour and target row = height[col].
- **Accept with `FALL_ANIM`=0, or with target row = `ROWS`-1:** commit at the accept edge.
  - Write the cell and increment the height.
  - Drive `done_*` for the following cycle.
  - Stay in IDLE.
- **Accept with `FALL_ANIM`=1 and target row < `ROWS`-1:** go to FALL with fall_row = `ROWS`-1.
- **FALL:**
  - `board` shows the latched colour at (col, fall_row); the underlying cell stays empty.
  - On `step` with fall_row > target: decrement fall_row by 1.
  - On `step` with fall_row == target: commit, pulse `done_*`, return to IDLE.
  - Without `step`: hold.
- **`win` change:** `win` going nonzero mid-FALL does not abort the fall; it only blocks the next accept.
- **Reset or `clear`:**
  - All cells 00, all heights 0, state IDLE.
  - Any in-flight fall is discarded; no `done_valid` or `reject` is generated.
  - `reset` has priority over `clear`; `clear` has priority over every other input.
- **Status outputs:** `col_full` and `board_full` are combinational from the heights.

## Timing
- **Reset values:**
  - `board` all zero.
  - `col_full`=0, `board_full`=0, `busy`=0, `done_valid`=0, `reject`=0, `done_col`/`done_row`/`done_colour`=0.
  - `drop_ready`=0 while `reset` is low.
- **Immediate commit:** accept at edge N makes the board, `col_full` and `done_valid` visible in the cycle after N.
- **Back-to-back drops:** one accepted drop per cycle is sustained in immediate mode. A second drop into the same column in the next cycle sees the updated height.
- **Animated drop:** accept at edge N sets `busy`=1 from N+1. The piece lands on the (`ROWS`-1-target+1)-th `step` edge after N. `done_valid` is high for one cycle after that edge, and `drop_ready` returns high in the same cycle.
- **Step timing:** a `step` coinciding with the accept edge is ignored.
- **Reject:** `reject` is high for the single cycle after the refusing accept edge, and `drop_ready` stays high.
- **Overlap:** `done_valid` and `reject` are never high in the same cycle.

## Test plan
- **Immediate stack:** `FALL_ANIM`=0, defaults. Six drops into column 3 with alternating colours on consecutive cycles.
  - Response: `done_row` reads 0..5 and column 3 reads 0x999 (`01`, `10` alternating, bottom first).
  - `col_full[3]` goes high after the sixth drop.
  - A seventh drop gives `reject`=1 and leaves `board` unchanged.
- **Animation:** `FALL_ANIM`=1, empty board, drop colour 1 into column 0, then six `step` pulses.
  - Response: overlay walks rows 5→0 with `busy`=1 throughout.
  - `done_valid` comes one cycle after the 6th step with row 0, colour 1.
  - `drop_ready` is 0 during the fall.
- **Invalid column:** `drop_col`=7 with `COLS`=7 → `reject` pulse; heights unchanged.
- **Win freeze:** set `win`=2'b01 mid-fall.
  - The fall completes and `done_valid` fires.
  - Afterwards `drop_ready`=0 and `drop_valid` is ignored.
- **Clear mid-fall:** assert `clear` during FALL.
  - Next cycle: `board`=0, `busy`=0, no `done_valid`.
  - Same check with `reset` held low.
- **Full board:** `COLS`=4, `ROWS`=4, immediate mode, 16 legal drops.
  - `board_full` rises in the cycle after the 16th accept.
  - The next request is rejected.
